// File: rtl/ahb_pkg.sv
// Shared AHB types: transfer/response encodings, master count limit and SPLIT FSM states.
package ahb_pkg;

  localparam int unsigned AHB_MAX_MASTERS = 16;
  localparam int unsigned AHB_MST_W       = 4;

  typedef enum logic [1:0] {
    HTransIdle   = 2'b00,
    HTransBusy   = 2'b01,
    HTransNonseq = 2'b10,
    HTransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRespOkay  = 2'b00,
    HRespError = 2'b01,
    HRespRetry = 2'b10,
    HRespSplit = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSplit1,
    StSplit2
  } split_state_t;

  function automatic logic htrans_active(htrans_t t);
    return (t == HTransNonseq) || (t == HTransSeq);
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N.
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int unsigned N = AHB_MAX_MASTERS
) (
  input  logic [N-1:0]           req_i,
  input  logic [AHB_MST_W-1:0]   last_i,
  output logic [N-1:0]           grant_o,
  output logic [AHB_MST_W-1:0]   idx_o,
  output logic                   valid_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  int unsigned     cand;
  logic [IdxW-1:0] cand_w;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    cand_w  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand   = (32'(last_i) + i) % N;
      cand_w = IdxW'(cand);
      if (!valid_o && req_i[cand_w]) begin
        valid_o         = 1'b1;
        grant_o[cand_w] = 1'b1;
        idx_o           = AHB_MST_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ahb_split_controller.sv
// Slave-side SPLIT scheduler: splits unlocked transfers while the backend is busy and
// releases recorded masters round-robin. Define AHB_SPLIT_SVA_EN to compile in assertions.
module ahb_split_controller
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  input  logic        svc_busy,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLITx,
  output logic [15:0] split_pending
);

  localparam logic [AHB_MST_W-1:0] LastRst = AHB_MST_W'(NUM_MASTERS - 1);

  split_state_t           state_q, state_d;
  logic [AHB_MST_W-1:0]   split_mst_q, split_mst_d;
  logic [AHB_MST_W-1:0]   last_q, last_d;
  logic [NUM_MASTERS-1:0] pend_q, pend_d;
  logic [NUM_MASTERS-1:0] hsplit_q, hsplit_d;
  logic [NUM_MASTERS-1:0] set_mask, grant, rel_mask;
  logic [AHB_MST_W-1:0]   pick_idx;
  logic                   pick_valid, rel_fire, addr_valid;

  assign addr_valid = HSEL & HREADY & htrans_active(htrans_t'(HTRANS));

  always_comb begin
    state_d     = state_q;
    split_mst_d = split_mst_q;
    HREADYOUT   = 1'b1;
    HRESP       = HRespOkay;
    set_mask    = '0;
    unique case (state_q)
      StIdle: begin
        if (addr_valid && svc_busy) begin
          if (HMASTLOCK) begin
            state_d = StWait;
          end else begin
            state_d     = StSplit1;
            split_mst_d = HMASTER;
          end
        end
      end
      StWait: begin
        // A new address here can only arrive with svc_busy low, so it is a zero-wait OKAY.
        HREADYOUT = !svc_busy;
        if (!svc_busy) state_d = StIdle;
      end
      StSplit1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRespSplit;
        state_d   = StSplit2;
      end
      StSplit2: begin
        HRESP   = HRespSplit;
        state_d = StIdle;
        // Out-of-range master numbers match no bit and are dropped.
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          if (32'(split_mst_q) == i) set_mask[i] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  ahb_rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req_i   (pend_q),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign rel_fire = !svc_busy && pick_valid;
  assign rel_mask = rel_fire ? grant : '0;

  always_comb begin
    hsplit_d = rel_mask;
    last_d   = rel_fire ? pick_idx : last_q;
    // A re-split of a master being released keeps its pending bit.
    pend_d   = (pend_q & ~rel_mask) | set_mask;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      split_mst_q <= '0;
      last_q      <= LastRst;
      pend_q      <= '0;
      hsplit_q    <= '0;
    end else begin
      state_q     <= state_d;
      split_mst_q <= split_mst_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      hsplit_q    <= hsplit_d;
    end
  end

  always_comb begin
    HSPLITx                         = '0;
    split_pending                   = '0;
    HSPLITx[NUM_MASTERS-1:0]        = hsplit_q;
    split_pending[NUM_MASTERS-1:0]  = pend_q;
  end

`ifdef AHB_SPLIT_SVA_EN
  a_hsplit_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
    $countones(HSPLITx) <= 1);
  a_split_seq: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (state_q == StSplit1) |=> (state_q == StSplit2));
  a_rel_pending: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (HSPLITx & ~$past(split_pending)) == 16'h0000);
  a_lock_nosplit: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (state_q == StIdle && addr_valid && HMASTLOCK) |=> (state_q != StSplit1));
  a_resp_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (HRESP != HRespError) && (HRESP != HRespRetry));
`else
  // Assertions compiled out; behaviour unchanged.
`endif

endmodule

// File: doc/ahb_split_controller.md
# ahb_split_controller

Slave-side SPLIT scheduler for the AHB fabric built around `ahb_arbiter`. When the attached slave backend is busy, it answers a transfer with a two-cycle SPLIT response and records the requesting master. When the backend frees up, it releases recorded masters round-robin by pulsing their `HSPLITx` bit, which feeds the arbiter's `HSPLIT` input. Locked transfers are never split; they are stalled with wait states instead.

## Interface
Parameters:
- `NUM_MASTERS`, default 16: number of masters tracked, 1..16. Bits at and above `NUM_MASTERS` in `HSPLITx` and `split_pending` are tied to 0.

Ports:
- `HCLK`  in  1: bus clock; the only clock.
- `HRESETn`  in  1: reset, asynchronous and active-low.
- `HSEL`  in  1: slave select, address phase.
- `HTRANS`  in  2: transfer type. IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HREADY`  in  1: bus-level ready; an address is accepted only when it is 1.
- `HMASTER`  in  4: master owning the current address phase (from the arbiter).
- `HMASTLOCK`  in  1: current transfer is locked.
- `svc_busy`  in  1: backend cannot service a transfer this cycle.
- `HREADYOUT`  out  1: slave ready.
- `HRESP`  out  2: response. OKAY=00, ERROR=01, RETRY=10, SPLIT=11; ERROR and RETRY are never driven.
- `HSPLITx`  out  16: registered one-cycle split-release pulses, to the arbiter's `HSPLIT`.
- `split_pending`  out  16: registered mask of masters currently split.

## Operation
- Valid address phase: `HSEL & HREADY & HTRANS[1]`. IDLE or BUSY transfers get a zero-wait OKAY.
- The FSM's next state is decided only on a valid address phase.
- FSM states and transitions:
  - `IDLE`: `HREADYOUT`=1, OKAY. On a valid address:
    - `svc_busy`=0: stay in `IDLE` (zero-wait OKAY).
    - `svc_busy`=1 and `HMASTLOCK`=1: go to `WAIT`.
    - `svc_busy`=1 and `HMASTLOCK`=0: go to `SPLIT1` and capture `HMASTER` into `split_mst`.
  - `WAIT`: `HRESP`=OKAY, `HREADYOUT`=`!svc_busy` (combinational). Exits on `!svc_busy`, applying the same decision as `IDLE` to any new valid address in that cycle.
  - `SPLIT1`: `HREADYOUT`=0, `HRESP`=SPLIT. Always goes to `SPLIT2`.
  - `SPLIT2`: `HREADYOUT`=1, `HRESP`=SPLIT. Sets `split_pending[split_mst]` at the clock edge ending this cycle, then goes to `IDLE`. Any address presented during `SPLIT2` is treated as cancelled and is ignored.
- Release: while `svc_busy`=0 and `split_pending`≠0, exactly one master is chosen per cycle.
  - Choice is round-robin, starting at `last_rel+1` modulo `NUM_MASTERS`.
  - Next edge: `HSPLITx[m]` is set for one cycle, `split_pending[m]` is cleared and `last_rel` is set to m.
- Simultaneous events:
  - A master being set in `SPLIT2` is not releasable in that same cycle; it becomes eligible next cycle.
  - A master that is already pending and addresses the slave again is split again; its pending bit stays 1.
- A `split_mst` value ≥ `NUM_MASTERS` is dropped and no pending bit is set.

## Timing
- Reset values: `HREADYOUT`=1, `HRESP`=OKAY, `HSPLITx`=0, `split_pending`=0, FSM=`IDLE`, `last_rel`=`NUM_MASTERS-1` (so master 0 is checked first).
- Split response: exactly 2 data-phase cycles, as SPLIT1 then SPLIT2.
- Release latency: `HSPLITx` pulses on the edge after the first cycle in which `svc_busy` is 0 and the bit is pending. A burst of k pending masters needs k consecutive cycles.
- `HSPLITx` is never high for more than one cycle per release, and at most one bit is high at a time.
- Reset mid-operation (including during `SPLIT1`) clears all state immediately. Any in-progress SPLIT is abandoned and the pending mask is lost.

## Configuration
- `AHB_SPLIT_SVA_EN` defined: concurrent assertions are compiled in:
  - `$countones(HSPLITx)<=1`.
  - `SPLIT1 |=> SPLIT2`.
  - `HSPLITx[m] |-> $past(split_pending[m])`.
  - `HMASTLOCK` transfers never see SPLIT.
  - `HRESP` is never ERROR or RETRY.
- `AHB_SPLIT_SVA_EN` undefined: no assertions; RTL behaviour is identical.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` and `hresp_t` enums carrying the encodings above.
  - `AHB_MAX_MASTERS`=16.
  - The FSM state enum `split_state_t`.
- One sub-module: `ahb_rr_pick`, a combinational round-robin one-hot picker. Inputs are the request mask and `last_rel`; outputs are a one-hot grant and its index. It can be reused by the arbiter.

## Test plan
- Reset, then an OKAY transfer from master 2 with `svc_busy`=0 → `HREADYOUT`=1, `HRESP`=00 with zero waits; `split_pending`=0.
- `svc_busy`=1, NONSEQ from master 5 → SPLIT1 (`HREADYOUT`=0, `HRESP`=11), then SPLIT2 (`HREADYOUT`=1, `HRESP`=11), then `split_pending`=0x0020.
- Masters 1, 5 and 9 pending, `last_rel`=5, then `svc_busy` drops → `HSPLITx` pulses 0x0200, 0x0002, 0x0020 on three consecutive cycles; pending mask ends at 0.
- Locked NONSEQ from master 3 with `svc_busy`=1 for 4 cycles → 4 cycles of `HREADYOUT`=0 with OKAY, never SPLIT; `split_pending` unchanged.
- `svc_busy` falls during SPLIT2 for master 7 → no `HSPLITx[7]` that cycle; pulse arrives exactly one cycle after `split_pending[7]` sets.
- `HRESETn` asserted during SPLIT1 with pending 0x0011 → outputs return to reset values immediately, with no `HSPLITx` pulse afterwards.
